// File: rtl/demux_1x8.sv
// Registered 1-to-8 demultiplexer built as a three-level tree of 1-to-2 cells.
// PIPE=0 registers only the leaves; PIPE=1 adds a register after every tree level.
module demux_1x8 #(
    parameter int DATA_W = 1,
    parameter int PIPE   = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] i,
    output logic [DATA_W-1:0] y0,
    output logic [DATA_W-1:0] y1,
    output logic [DATA_W-1:0] y2,
    output logic [DATA_W-1:0] y3,
    output logic [DATA_W-1:0] y4,
    output logic [DATA_W-1:0] y5,
    output logic [DATA_W-1:0] y6,
    output logic [DATA_W-1:0] y7,
    output logic [7:0]        route_oh
);

    // Each tree lane carries {valid, data}; valid is en routed like the data,
    // so at the leaves it becomes route_oh bit-for-bit.
    localparam int CW = DATA_W + 1;

    logic [CW-1:0]       root;
    logic [1:0][CW-1:0]  l1_c;
    logic [1:0][CW-1:0]  s1_d;
    logic [1:0]          s1_sel;
    logic [3:0][CW-1:0]  l2_c;
    logic [3:0][CW-1:0]  s2_d;
    logic                s2_sel;
    logic [7:0][CW-1:0]  leaf_c;
    logic [7:0][CW-1:0]  leaf_q;

    // One leg of a 1-to-2 cell: leg b passes d only when s equals b.
    function automatic logic [CW-1:0] cell_leg(input logic s, input logic [CW-1:0] d,
                                               input logic b);
        return (s == b) ? d : '0;
    endfunction

    always_comb begin
        root    = {en, (en ? i : '0)};
        l1_c[0] = cell_leg(sel[2], root, 1'b0);
        l1_c[1] = cell_leg(sel[2], root, 1'b1);
    end

    always_comb begin
        l2_c = '0;
        for (int k = 0; k < 2; k++) begin
            l2_c[2*k]   = cell_leg(s1_sel[1], s1_d[k], 1'b0);
            l2_c[2*k+1] = cell_leg(s1_sel[1], s1_d[k], 1'b1);
        end
    end

    always_comb begin
        leaf_c = '0;
        for (int k = 0; k < 4; k++) begin
            leaf_c[2*k]   = cell_leg(s2_sel, s2_d[k], 1'b0);
            leaf_c[2*k+1] = cell_leg(s2_sel, s2_d[k], 1'b1);
        end
    end

    generate
        if (PIPE != 0) begin : g_pipe
            // Unconsumed select bits ride along with the partial data.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s1_d   <= '0;
                    s1_sel <= '0;
                    s2_d   <= '0;
                    s2_sel <= 1'b0;
                end else begin
                    s1_d   <= l1_c;
                    s1_sel <= sel[1:0];
                    s2_d   <= l2_c;
                    s2_sel <= s1_sel[0];
                end
            end
        end else begin : g_flat
            assign s1_d   = l1_c;
            assign s1_sel = sel[1:0];
            assign s2_d   = l2_c;
            assign s2_sel = s1_sel[0];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            leaf_q <= '0;
        end else begin
            leaf_q <= leaf_c;
        end
    end

    assign y0 = leaf_q[0][DATA_W-1:0];
    assign y1 = leaf_q[1][DATA_W-1:0];
    assign y2 = leaf_q[2][DATA_W-1:0];
    assign y3 = leaf_q[3][DATA_W-1:0];
    assign y4 = leaf_q[4][DATA_W-1:0];
    assign y5 = leaf_q[5][DATA_W-1:0];
    assign y6 = leaf_q[6][DATA_W-1:0];
    assign y7 = leaf_q[7][DATA_W-1:0];

    always_comb begin
        route_oh = '0;
        for (int k = 0; k < 8; k++) begin
            route_oh[k] = leaf_q[k][CW-1];
        end
    end

endmodule

// File: tb/tb_demux_1x8.sv
// Directed bench for demux_1x8: a flat 1-bit instance and a 4-bit pipelined instance.
module tb_demux_1x8;

    logic       clk;
    logic       rst_n;

    logic       en_a;
    logic [2:0] sel_a;
    logic [0:0] i_a;
    logic [0:0] ya [8];
    logic [7:0] oh_a;

    logic       en_b;
    logic [2:0] sel_b;
    logic [3:0] i_b;
    logic [3:0] yb [8];
    logic [7:0] oh_b;

    logic [7:0]  y_all_a;
    logic [31:0] y_all_b;

    int checks;
    int errors;

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    demux_1x8 #(.DATA_W(1), .PIPE(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .sel(sel_a), .i(i_a),
        .y0(ya[0]), .y1(ya[1]), .y2(ya[2]), .y3(ya[3]),
        .y4(ya[4]), .y5(ya[5]), .y6(ya[6]), .y7(ya[7]),
        .route_oh(oh_a)
    );

    demux_1x8 #(.DATA_W(4), .PIPE(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .sel(sel_b), .i(i_b),
        .y0(yb[0]), .y1(yb[1]), .y2(yb[2]), .y3(yb[3]),
        .y4(yb[4]), .y5(yb[5]), .y6(yb[6]), .y7(yb[7]),
        .route_oh(oh_b)
    );

    always_comb begin
        y_all_a = '0;
        y_all_b = '0;
        for (int k = 0; k < 8; k++) begin
            y_all_a[k]       = ya[k][0];
            y_all_b[4*k +: 4] = yb[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk);
    endtask

    logic [7:0]  sweep_exp [8];
    logic [2:0]  pipe_sel  [3];
    logic [3:0]  pipe_i    [3];
    logic [31:0] pipe_y    [3];
    logic [7:0]  pipe_oh   [3];
    logic [2:0]  s;

    initial begin
        checks = 0;
        errors = 0;
        sweep_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        pipe_sel  = '{3'd2, 3'd7, 3'd0};
        pipe_i    = '{4'hA, 4'h5, 4'hF};
        pipe_y    = '{32'h0000_0A00, 32'h5000_0000, 32'h0000_000F};
        pipe_oh   = '{8'h04, 8'h80, 8'h01};

        // reset held with active inputs
        rst_n = 1'b0;
        en_a = 1'b1; sel_a = 3'd5; i_a = 1'b1;
        en_b = 1'b1; sel_b = 3'd5; i_b = 4'hF;
        repeat (3) next_cycle();
        check("rst_y_a",  {24'd0, y_all_a}, 32'd0);
        check("rst_oh_a", {24'd0, oh_a}, 32'd0);
        check("rst_y_b",  y_all_b, 32'd0);
        check("rst_oh_b", {24'd0, oh_b}, 32'd0);
        en_b = 1'b0;
        rst_n = 1'b1;

        // full sweep on the flat instance
        for (int n = 0; n < 8; n++) begin
            sel_a = 3'(n); i_a = 1'b1; en_a = 1'b1;
            next_cycle();
            check($sformatf("sweep_y%0d", n),  {24'd0, y_all_a}, {24'd0, sweep_exp[n]});
            check($sformatf("sweep_oh%0d", n), {24'd0, oh_a},    {24'd0, sweep_exp[n]});
        end

        // asynchronous reset between edges while y7 is high
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_y_a",  {24'd0, y_all_a}, 32'd0);
        check("async_rst_oh_a", {24'd0, oh_a}, 32'd0);
        next_cycle();
        rst_n = 1'b1;

        // random select, i=1 then i=0
        for (int n = 0; n < 10; n++) begin
            s = 3'($urandom_range(0, 7));
            sel_a = s; en_a = 1'b1; i_a = (n < 8) ? 1'b1 : 1'b0;
            next_cycle();
            check($sformatf("rand_y_%0d", n), {24'd0, y_all_a},
                  (n < 8) ? (32'd1 << s) : 32'd0);
            check($sformatf("rand_oh_%0d", n), {24'd0, oh_a}, 32'd1 << s);
        end

        // enable gating
        en_a = 1'b0; sel_a = 3'd6; i_a = 1'b1;
        next_cycle();
        check("en0_y",  {24'd0, y_all_a}, 32'd0);
        check("en0_oh", {24'd0, oh_a}, 32'd0);
        en_a = 1'b1;
        next_cycle();
        check("en1_y",  {24'd0, y_all_a}, 32'h40);
        check("en1_oh", {24'd0, oh_a}, 32'h40);
        en_a = 1'b0;

        // pipelined stream: results three edges after each input
        for (int c = 0; c < 7; c++) begin
            if (c >= 3) begin
                check($sformatf("pipe_y_%0d", c),  y_all_b, pipe_y[c-3]);
                check($sformatf("pipe_oh_%0d", c), {24'd0, oh_b}, {24'd0, pipe_oh[c-3]});
            end else if (c > 0) begin
                check($sformatf("pipe_lat_%0d", c), y_all_b, 32'd0);
            end
            if (c < 3) begin
                en_b = 1'b1; sel_b = pipe_sel[c]; i_b = pipe_i[c];
            end else begin
                en_b = 1'b0; sel_b = 3'd0; i_b = 4'h0;
            end
            next_cycle();
        end

        // reset in mid-stream flushes in-flight data
        en_b = 1'b1; sel_b = 3'd3; i_b = 4'hC;
        next_cycle();
        sel_b = 3'd4; i_b = 4'h9;
        next_cycle();
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_y_b",  y_all_b, 32'd0);
        check("mid_rst_oh_b", {24'd0, oh_b}, 32'd0);
        next_cycle();
        rst_n = 1'b1;
        en_b = 1'b1; sel_b = 3'd1; i_b = 4'h3;
        next_cycle();
        en_b = 1'b0; sel_b = 3'd0; i_b = 4'h0;
        check("flush_1", y_all_b, 32'd0);
        next_cycle();
        check("flush_2", y_all_b, 32'd0);
        next_cycle();
        check("post_rst_y",  y_all_b, 32'h0000_0030);
        check("post_rst_oh", {24'd0, oh_b}, 32'h02);
        next_cycle();
        check("post_rst_idle", y_all_b, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
